// File: rtl/cpu_pkg.sv
// Shared types and constants for the divide-loop accelerator.
// Holds the sequencer state encoding and the memory cells that receive
// the loop's quotient and residual.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ITER,
        FIX,
        WR_Q,
        WR_R,
        DONE
    } t_div_state;

    localparam logic [15:0] DIV_Q_ADDR = 16'd1;
    localparam logic [15:0] DIV_R_ADDR = 16'd2;

endpackage

// File: rtl/div_iter.sv
// Restoring divider datapath: one quotient bit per step.
// The dividend is loaded into the quotient register and shifted out MSB-first
// into a W+1-bit partial remainder; the shifted-in bits form the quotient.
module div_iter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] q,
    output logic [W-1:0] r
);

    logic [W:0]   rem;
    logic [W-1:0] quo;
    logic [W:0]   rem_sh;
    logic [W:0]   diff;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        rem_sh = {rem[W-1:0], quo[W-1]};
        diff   = rem_sh - {1'b0, b};
    end

    // Remainder/quotient registers: load clears the remainder, step restores on borrow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= '0;
            quo <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= a;
        end else if (step) begin
            if (!diff[W]) begin
                rem <= diff;
                quo <= {quo[W-2:0], 1'b1};
            end else begin
                rem <= rem_sh;
                quo <= {quo[W-2:0], 1'b0};
            end
        end
    end

    assign q = quo;
    assign r = rem[W-1:0];

endmodule

// File: rtl/div_seq.sv
// Divide-loop sequencer: replaces the repeated-subtraction loop with an
// iterative restoring divide, writes k = ceil(a/b) and f = a - k*b to memory,
// loads D with f and redirects the PC past the loop.
// Optional macro DIV_EARLY_TERM_EN: skip the leading-zero iterations of a.
module div_seq
    import cpu_pkg::*;
#(
    parameter int           W      = 16,
    parameter logic [W-1:0] Q_ADDR = W'(DIV_Q_ADDR),
    parameter logic [W-1:0] R_ADDR = W'(DIV_R_ADDR)
) (
    input  logic         Clk,
    input  logic         ResetN,
    input  logic         StartDiv102,
    input  logic [W-1:0] Divident,
    input  logic [W-1:0] Divisor,
    input  logic [W-1:0] ExitPc,
    input  logic         FlushDiv,
    input  logic         MemWrGnt,
    output logic         Stall,
    output logic         Busy,
    output logic         Reject,
    output logic         MemWrReq,
    output logic [W-1:0] MemWrAddr,
    output logic [W-1:0] MemWrData,
    output logic         D_WrEn,
    output logic [W-1:0] D_Data,
    output logic         PcRedirect,
    output logic [W-1:0] JmpTarget,
    output logic         DivDone
);

    localparam int CW = $clog2(W);

    t_div_state          state;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_init;
    logic [W-1:0]        b_reg;
    logic [W-1:0]        pc_reg;
    logic signed [W-1:0] f_reg;
    logic [W-1:0]        load_a;
    logic [W-1:0]        q;
    logic [W-1:0]        r;
    logic                operands_ok;
    logic                start_ok;
    logic                rem_nz;

`ifdef DIV_EARLY_TERM_EN
    function automatic int clz(input logic [W-1:0] v);
        int n;
        n = W;
        for (int i = 0; i < W; i++) begin
            if (v[i]) n = W - 1 - i;
        end
        return n;
    endfunction

    // Normalise a so its leading one enters the remainder on the first step
    always_comb begin
        load_a   = Divident << clz(Divident);
        cnt_init = CW'(W - 1 - clz(Divident));
    end
`else
    // Full-width divide: every bit of a passes through the remainder
    always_comb begin
        load_a   = Divident;
        cnt_init = CW'(W - 1);
    end
`endif

    // Both operands must be strictly positive; anything else stays in software
    assign operands_ok = !Divident[W-1] && (Divident != '0) &&
                         !Divisor[W-1]  && (Divisor  != '0);
    assign start_ok    = (state == IDLE) && StartDiv102 && !FlushDiv && operands_ok;
    assign rem_nz      = (r != '0);

    div_iter #(.W(W)) u_iter (
        .clk   (Clk),
        .rst_n (ResetN),
        .load  (start_ok),
        .step  ((state == ITER) && !FlushDiv),
        .a     (load_a),
        .b     (b_reg),
        .q     (q),
        .r     (r)
    );

    // Sequencer FSM with registered outputs; flush wins over every transition
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state      <= IDLE;
            cnt        <= '0;
            b_reg      <= '0;
            pc_reg     <= '0;
            f_reg      <= '0;
            Stall      <= 1'b0;
            Busy       <= 1'b0;
            Reject     <= 1'b0;
            MemWrReq   <= 1'b0;
            MemWrAddr  <= '0;
            MemWrData  <= '0;
            D_WrEn     <= 1'b0;
            D_Data     <= '0;
            PcRedirect <= 1'b0;
            JmpTarget  <= '0;
            DivDone    <= 1'b0;
        end else begin
            Reject     <= 1'b0;
            D_WrEn     <= 1'b0;
            D_Data     <= '0;
            PcRedirect <= 1'b0;
            JmpTarget  <= '0;
            DivDone    <= 1'b0;
            if (FlushDiv) begin
                state     <= IDLE;
                Stall     <= 1'b0;
                Busy      <= 1'b0;
                MemWrReq  <= 1'b0;
                MemWrAddr <= '0;
                MemWrData <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (StartDiv102) begin
                            if (operands_ok) begin
                                state  <= ITER;
                                cnt    <= cnt_init;
                                b_reg  <= Divisor;
                                pc_reg <= ExitPc;
                                Stall  <= 1'b1;
                                Busy   <= 1'b1;
                            end else begin
                                Reject <= 1'b1;
                            end
                        end
                    end
                    ITER: begin
                        if (cnt == '0) state <= FIX;
                        else           cnt   <= cnt - 1'b1;
                    end
                    FIX: begin
                        // Ceiling correction: a non-zero remainder means one more subtraction
                        state     <= WR_Q;
                        MemWrReq  <= 1'b1;
                        MemWrAddr <= Q_ADDR;
                        MemWrData <= rem_nz ? q + 1'b1 : q;
                        f_reg     <= rem_nz ? $signed(r - b_reg) : '0;
                    end
                    WR_Q: begin
                        if (MemWrGnt) begin
                            state     <= WR_R;
                            MemWrAddr <= R_ADDR;
                            MemWrData <= f_reg;
                        end
                    end
                    WR_R: begin
                        if (MemWrGnt) begin
                            state      <= DONE;
                            MemWrReq   <= 1'b0;
                            MemWrAddr  <= '0;
                            MemWrData  <= '0;
                            DivDone    <= 1'b1;
                            D_WrEn     <= 1'b1;
                            D_Data     <= f_reg;
                            PcRedirect <= 1'b1;
                            JmpTarget  <= pc_reg;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        Stall <= 1'b0;
                        Busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed testbench for div_seq: hand-computed quotient/residual vectors,
// cycle timing of writes and completion, reject, flush, back-pressure and reset.
module tb_div_seq;

    localparam int W = 16;

    logic         Clk = 1'b0;
    logic         ResetN = 1'b0;
    logic         StartDiv102 = 1'b0;
    logic [W-1:0] Divident = '0;
    logic [W-1:0] Divisor = '0;
    logic [W-1:0] ExitPc = '0;
    logic         FlushDiv = 1'b0;
    logic         MemWrGnt = 1'b1;
    logic         Stall;
    logic         Busy;
    logic         Reject;
    logic         MemWrReq;
    logic [W-1:0] MemWrAddr;
    logic [W-1:0] MemWrData;
    logic         D_WrEn;
    logic [W-1:0] D_Data;
    logic         PcRedirect;
    logic [W-1:0] JmpTarget;
    logic         DivDone;

    div_seq dut (
        .Clk         (Clk),
        .ResetN      (ResetN),
        .StartDiv102 (StartDiv102),
        .Divident    (Divident),
        .Divisor     (Divisor),
        .ExitPc      (ExitPc),
        .FlushDiv    (FlushDiv),
        .MemWrGnt    (MemWrGnt),
        .Stall       (Stall),
        .Busy        (Busy),
        .Reject      (Reject),
        .MemWrReq    (MemWrReq),
        .MemWrAddr   (MemWrAddr),
        .MemWrData   (MemWrData),
        .D_WrEn      (D_WrEn),
        .D_Data      (D_Data),
        .PcRedirect  (PcRedirect),
        .JmpTarget   (JmpTarget),
        .DivDone     (DivDone)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Observations from the most recent run
    int           rej_n, rej_cnt, stall_first, stall_cnt;
    int           wq_n, wr_n, done_n, nwr, rst_hit;
    logic         busy_after_flush, dwe, redir;
    logic [W-1:0] mem1, mem2, d_val, jmp_val;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Number of ITER cycles the sequencer spends on dividend a
    function automatic int iters(input logic [W-1:0] a);
`ifdef DIV_EARLY_TERM_EN
        int h;
        h = 0;
        for (int i = 0; i < W; i++) if (a[i]) h = i;
        return h + 1;
`else
        return W;
`endif
    endfunction

    // Start one operation at cycle T and observe cycles T+1 .. T+limit
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] pc,
                       input int hold, input logic [W-1:0] hold_data, input int flush_at,
                       input int extra_start_at, input int rst_in_wrr, input int limit);
        int hold_left;
        hold_left = hold;
        rej_n = 0; rej_cnt = 0; stall_first = 0; stall_cnt = 0;
        wq_n = 0; wr_n = 0; done_n = 0; nwr = 0; rst_hit = 0;
        busy_after_flush = 1'bx; dwe = 0; redir = 0;
        mem1 = 16'hDEAD; mem2 = 16'hDEAD; d_val = 16'hDEAD; jmp_val = 16'hDEAD;
        @(negedge Clk);
        Divident = a; Divisor = b; ExitPc = pc; StartDiv102 = 1'b1;
        @(negedge Clk);
        StartDiv102 = 1'b0; Divident = '0; Divisor = '0; ExitPc = '0;
        for (int n = 1; n <= limit; n++) begin
            FlushDiv = (n == flush_at);
            if (n == extra_start_at) begin
                StartDiv102 = 1'b1; Divident = 16'd9; Divisor = 16'd2; ExitPc = 16'h1111;
            end else begin
                StartDiv102 = 1'b0;
            end
            if (rst_in_wrr != 0 && MemWrReq && MemWrAddr == 16'd2) begin
                ResetN = 1'b0;
                #1;
                check("wrr_rst_ctrl", {Stall, Busy, Reject, MemWrReq, D_WrEn, PcRedirect, DivDone}, 0);
                check("wrr_rst_data", {MemWrAddr, MemWrData}, 0);
                rst_hit = 1;
                break;
            end
            if (MemWrReq && hold_left > 0) begin
                MemWrGnt = 1'b0;
                hold_left--;
                check("hold_addr", MemWrAddr, 32'd1);
                check("hold_data", MemWrData, hold_data);
            end else begin
                MemWrGnt = 1'b1;
            end
            if (Reject) begin
                rej_cnt++;
                if (rej_n == 0) rej_n = n;
            end
            if (Stall) begin
                stall_cnt++;
                if (stall_first == 0) stall_first = n;
            end
            if (flush_at > 0 && n == flush_at + 1) busy_after_flush = Busy;
            if (MemWrReq && MemWrGnt) begin
                nwr++;
                if (MemWrAddr == 16'd1) begin mem1 = MemWrData; wq_n = n; end
                else if (MemWrAddr == 16'd2) begin mem2 = MemWrData; wr_n = n; end
            end
            if (DivDone) begin
                done_n = n; d_val = D_Data; jmp_val = JmpTarget; dwe = D_WrEn; redir = PcRedirect;
                break;
            end
            if (n < limit) @(negedge Clk);
        end
        FlushDiv = 1'b0; StartDiv102 = 1'b0; MemWrGnt = 1'b1;
    endtask

    // Results and timing of a completed divide
    task automatic verify(input string tag, input logic [W-1:0] a, input logic [W-1:0] pc,
                          input logic [W-1:0] k, input logic [W-1:0] f, input int hold);
        int it;
        it = iters(a);
        check({tag, "_k"}, mem1, k);
        check({tag, "_f"}, mem2, f);
        check({tag, "_d"}, d_val, f);
        check({tag, "_jmp"}, jmp_val, pc);
        check({tag, "_pulses"}, {dwe, redir}, 2'b11);
        check({tag, "_wq_cyc"}, wq_n, it + 2 + hold);
        check({tag, "_wr_cyc"}, wr_n, it + 3 + hold);
        check({tag, "_done_cyc"}, done_n, it + 4 + hold);
        check({tag, "_nwr"}, nwr, 2);
        check({tag, "_stall_first"}, stall_first, 1);
        check({tag, "_stall_len"}, stall_cnt, it + 4 + hold);
        @(negedge Clk);
        check({tag, "_after"}, {DivDone, Busy, Stall, PcRedirect}, 0);
    endtask

    task automatic verify_reject(input string tag);
        check({tag, "_rej_cyc"}, rej_n, 1);
        check({tag, "_rej_len"}, rej_cnt, 1);
        check({tag, "_stall"}, stall_cnt, 0);
        check({tag, "_nwr"}, nwr, 0);
        check({tag, "_done"}, done_n, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ResetN = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_ctrl", {Stall, Busy, Reject, MemWrReq, D_WrEn, PcRedirect, DivDone}, 0);
        check("rst_addr_data", {MemWrAddr, MemWrData}, 0);
        check("rst_d_jmp", {D_Data, JmpTarget}, 0);
        ResetN = 1'b1;
        @(negedge Clk);

        // 20000/10 divides exactly: k = 2000, f = 0
        run(16'd20000, 16'd10, 16'h0400, 0, '0, 0, 0, 0, 60);
        verify("d20000_10", 16'd20000, 16'h0400, 16'd2000, 16'd0, 0);

        // 7/2: k = 4, f = 7 - 8 = -1
        run(16'd7, 16'd2, 16'h0123, 0, '0, 0, 0, 0, 60);
        verify("d7_2", 16'd7, 16'h0123, 16'd4, 16'hFFFF, 0);

        // Operands outside the accelerated range
        run(16'd7, 16'd0, 16'h0050, 0, '0, 0, 0, 0, 25);
        verify_reject("rej_b0");
        run(16'd0, 16'd3, 16'h0050, 0, '0, 0, 0, 0, 25);
        verify_reject("rej_a0");
        run(16'hFFFB, 16'd3, 16'h0050, 0, '0, 0, 0, 0, 25);
        verify_reject("rej_aneg");

        // 100/7 with three cycles of back-pressure in WR_Q: k = 15, f = 100 - 105 = -5
        run(16'd100, 16'd7, 16'h0200, 3, 16'd15, 0, 0, 0, 60);
        verify("d100_7", 16'd100, 16'h0200, 16'd15, 16'hFFFB, 3);

        // Flush at T+5 during ITER, then a new start at T+8: 30/4 -> k = 8, f = -2
        run(16'd1000, 16'd3, 16'h0300, 0, '0, 5, 0, 0, 7);
        check("flush_busy", busy_after_flush, 1'b0);
        check("flush_nwr", nwr, 0);
        check("flush_done", done_n, 0);
        run(16'd30, 16'd4, 16'h0310, 0, '0, 0, 0, 0, 60);
        verify("d30_4", 16'd30, 16'h0310, 16'd8, 16'hFFFE, 0);

        // A second start at T+3 while busy is ignored: 50/5 -> k = 10, f = 0
        run(16'd50, 16'd5, 16'h0500, 0, '0, 0, 3, 0, 60);
        verify("d50_5_busy", 16'd50, 16'h0500, 16'd10, 16'd0, 0);

        // Reset asserted in WR_R: 1000/3 -> k = 334 already written, residual never written
        run(16'd1000, 16'd3, 16'h0600, 0, '0, 0, 0, 1, 60);
        check("wrr_hit", rst_hit, 1);
        check("wrr_k", mem1, 16'd334);
        check("wrr_nwr", nwr, 1);
        @(negedge Clk);
        check("wrr_held", {MemWrReq, Busy, DivDone}, 0);
        ResetN = 1'b1;
        @(negedge Clk);

        // Recovery after reset: 9/2 -> k = 5, f = -1
        run(16'd9, 16'd2, 16'h0700, 0, '0, 0, 0, 0, 60);
        verify("d9_2", 16'd9, 16'h0700, 16'd5, 16'hFFFF, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
